// File: rtl/ssid_hit_readout.sv
// ssid_hit_readout: per-SSID query reader over the HNM/HCM/HLM A ports.
// Streams the stored hit words oldest first, then pulses a completion summary.
module ssid_hit_readout #(
    parameter int SSIDBITS         = 12,
    parameter int COLINDEXBITS_HNM = 5,
    parameter int NCOLS_HNM        = 2**COLINDEXBITS_HNM,
    parameter int ROWINDEXBITS_HNM = SSIDBITS-COLINDEXBITS_HNM,
    parameter int HITINFOBITS      = 8,
    parameter int MAXHITNBITS      = 4,
    parameter int MAXHITS          = 8,
    parameter int ROWINDEXBITS_HLM = 10,
    parameter int NCOLS_HCM        = ROWINDEXBITS_HLM+MAXHITNBITS,
    parameter int NCOLS_HLM        = HITINFOBITS*MAXHITS
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        memBusy,
    input  logic                        queryValid,
    input  logic [SSIDBITS-1:0]         querySSID,
    output logic                        queryReady,
    output logic [ROWINDEXBITS_HNM-1:0] hnmAddr,
    input  logic [NCOLS_HNM-1:0]        hnmData,
    output logic [SSIDBITS-1:0]         hcmAddr,
    input  logic [NCOLS_HCM-1:0]        hcmData,
    output logic [ROWINDEXBITS_HLM-1:0] hlmAddr,
    input  logic [NCOLS_HLM-1:0]        hlmData,
    output logic                        hitValid,
    input  logic                        hitReady,
    output logic [HITINFOBITS-1:0]      hitInfo,
    output logic                        hitLast,
    output logic                        queryDone,
    output logic [MAXHITNBITS-1:0]      queryHitCount,
    output logic                        queryOverflow
);
    localparam int SLOTBITS = $clog2(MAXHITS);
    localparam logic [MAXHITNBITS-1:0] MAX_N = MAXHITNBITS'(MAXHITS);

    typedef enum logic [2:0] {IDLE, WAIT1, CHECK, WAITL1, LOAD, STREAM, DONE} state_t;

    state_t state, next;
    logic [MAXHITNBITS-1:0] n, eff;
    logic [NCOLS_HLM-1:0] row;
    logic [SLOTBITS-1:0] slot;
    logic ovf, hit;

    // hcmAddr doubles as the latched SSID; HCM is trusted only when the HNM bit is set
    assign n             = hcmData[MAXHITNBITS-1:0];
    assign hit           = hnmData[hcmAddr[COLINDEXBITS_HNM-1:0]] && n != '0;
    assign hitInfo       = row[slot*HITINFOBITS +: HITINFOBITS];
    assign hitLast       = hitValid && slot == '0;
    assign queryHitCount = queryDone ? eff : '0;
    assign queryOverflow = queryDone && ovf;

    always_ff @(posedge clock or negedge resetN)
        if (!resetN) state <= IDLE;
        else state <= next;

    always_comb begin
        next       = state;
        queryReady = 1'b0;
        hitValid   = 1'b0;
        queryDone  = 1'b0;
        unique case (state)
            IDLE: begin
                queryReady = !memBusy;
                if (queryValid && !memBusy) next = WAIT1;
            end
            WAIT1:  next = CHECK;
            CHECK:  next = hit ? WAITL1 : DONE;
            WAITL1: next = LOAD;
            LOAD:   next = STREAM;
            STREAM: begin
                hitValid = 1'b1;
                if (hitReady && slot == '0) next = DONE;
            end
            DONE: begin
                queryDone = 1'b1;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            hnmAddr <= '0;
            hcmAddr <= '0;
            hlmAddr <= '0;
            eff     <= '0;
            ovf     <= 1'b0;
            row     <= '0;
            slot    <= '0;
        end else begin
            if (queryValid && queryReady) begin
                hnmAddr <= querySSID[SSIDBITS-1:COLINDEXBITS_HNM];
                hcmAddr <= querySSID;
            end
            if (state == CHECK) begin
                eff <= hit ? (n > MAX_N ? MAX_N : n) : '0;
                ovf <= hit && n > MAX_N;
                if (hit) hlmAddr <= hcmData[NCOLS_HCM-1:MAXHITNBITS];
            end
            if (state == LOAD) begin
                row  <= hlmData;
                slot <= SLOTBITS'(eff - 1'b1);
            end
            if (hitValid && hitReady && slot != '0) slot <= slot - 1'b1;
        end
    end
endmodule

// File: doc/ssid_hit_readout.md
# ssid_hit_readout

Query-side reader for the SSID hit store. It sits directly downstream of the SSID storage block and reads that block's three block memories through their otherwise unused A ports:
- HNM: hit-new bitmap.
- HCM: per-SSID hit count plus HLM address.
- HLM: packed hit info.

For each accepted SSID it streams out every stored hit word, oldest first, with valid/ready handshakes on both sides. It then reports a one-cycle completion summary.

## Interface

Parameters:
- SSIDBITS, 12, SSID width
- COLINDEXBITS_HNM, 5, SSID low bits selecting the HNM column
- NCOLS_HNM, 32, HNM row width (2**COLINDEXBITS_HNM)
- ROWINDEXBITS_HNM, SSIDBITS-COLINDEXBITS_HNM, HNM address width
- HITINFOBITS, 8, width of one hit word
- MAXHITNBITS, 4, width of the HCM count field
- MAXHITS, 8, hit slots per HLM row
- ROWINDEXBITS_HLM, 10, HLM address width
- NCOLS_HCM, ROWINDEXBITS_HLM+MAXHITNBITS, HCM row layout {HLM address, count}, count in the LSBs
- NCOLS_HLM, HITINFOBITS*MAXHITS, HLM row width

Ports:
- clock  in  1  single clock for all logic and all memory ports
- resetN  in  1  asynchronous, active-low reset
- memBusy  in  1  storage block is clearing or has queued writes; no query accepted while high
- queryValid  in  1  query request
- querySSID  in  SSIDBITS  SSID to read
- queryReady  out  1  query accepted on an edge where queryValid && queryReady
- hnmAddr  out  ROWINDEXBITS_HNM  HNM port-A address
- hnmData  in  NCOLS_HNM  HNM port-A read data
- hcmAddr  out  SSIDBITS  HCM port-A address
- hcmData  in  NCOLS_HCM  HCM port-A read data
- hlmAddr  out  ROWINDEXBITS_HLM  HLM port-A address
- hlmData  in  NCOLS_HLM  HLM port-A read data
- hitValid  out  1  hitInfo valid
- hitReady  in  1  downstream accepts hitInfo
- hitInfo  out  HITINFOBITS  one hit word
- hitLast  out  1  marks the final hit of the query
- queryDone  out  1  one-cycle pulse at query completion
- queryHitCount  out  MAXHITNBITS  hits emitted for the completed query
- queryOverflow  out  1  stored count exceeded MAXHITS and the output was truncated

## Operation

Memory interface:
- Memories have 1-cycle read latency.
- The block never writes them; the write enables of the A ports stay tied low in the enclosing design.

FSM states: IDLE, WAIT1, CHECK, WAITL1, LOAD, STREAM, DONE.

- IDLE
  - queryReady = !memBusy.
  - On accept: latch SSID, register hnmAddr = SSID[SSIDBITS-1:COLINDEXBITS_HNM] and hcmAddr = SSID, go to WAIT1.
- WAIT1: wait one cycle for read data, go to CHECK.
- CHECK: sample hit = hnmData[SSID[COLINDEXBITS_HNM-1:0]], and n = hcmData[MAXHITNBITS-1:0].
  - If !hit or n==0: go to DONE with count 0. HCM content is stale unless the HNM bit is set, so it must be ignored in that case.
  - Otherwise: register hlmAddr = hcmData[NCOLS_HCM-1:MAXHITNBITS], set eff = min(n, MAXHITS), set overflow = (n > MAXHITS), go to WAITL1.
- WAITL1: go to LOAD.
- LOAD: capture hlmData into the row register, set slot = eff-1, present slot into hitInfo, assert hitValid, go to STREAM.
- STREAM
  - Slot k occupies row bits [(k+1)*HITINFOBITS-1 : k*HITINFOBITS]. Slot 0 is the newest hit; slot eff-1 is the oldest.
  - hitLast = (slot==0).
  - On hitValid && hitReady: if slot==0, drop hitValid and go to DONE; else decrement slot and present the next word.
- DONE
  - queryDone=1 for one cycle, with queryHitCount = emitted count and queryOverflow.
  - Go to IDLE.
- memBusy is sampled only in IDLE. A query already in flight completes regardless of memBusy.
- Overflow: n > MAXHITS emits slots MAXHITS-1..0 only.

## Timing

- Reset (async assert, sync release): state IDLE. All outputs 0, except queryReady, which follows !memBusy once in IDLE. Addresses are 0.
- Reset mid-query abandons the query: no queryDone and no hitValid afterwards.
- Let E0 be the acceptance edge.
  - hnmAddr and hcmAddr update at E0.
  - CHECK samples at E2.
  - Miss: queryDone is high in the cycle after E2, and queryReady is high again the cycle after that.
  - Hit: hlmAddr updates at E2, and the first hitValid is high in the cycle after E4.
- Throughput: one hit per cycle while hitReady=1.
  - hitInfo and hitLast hold stable while hitValid && !hitReady.
  - hitValid never drops without a handshake.
- Minimum spacing between queries: 4 cycles for a miss; 6+eff cycles for a hit.
- queryReady is 0 in every state except IDLE.

## Test plan

- Miss: HNM row 0x05 = 0, query 0x0A5 -> queryDone=1 in the cycle after E2, queryHitCount=0, hitValid never asserted.
- Two hits: HNM row 0x05 bit 5 set, HCM[0x0A5] = {addr 3, count 2}, HLM[3][15:0] = 0xA1B2 -> hitInfo 0xA1 then 0xB2, hitLast on 0xB2, queryDone with count 2.
- Backpressure: same setup as the two-hit case, hitReady low for 3 cycles on the first beat -> hitInfo stays 0xA1 for 3 cycles, no hit lost or repeated.
- Overflow: count 10, HLM row holds 0x01..0x08 in slots 7..0 -> emits 0x01..0x08 in that order, queryHitCount=8, queryOverflow=1.
- Stale/busy: HNM bit 0 while HCM count is 5 -> count 0 reported. With memBusy=1 and queryValid=1, queryReady stays 0 until memBusy falls, then the query is accepted on the next edge.
- Reset: resetN pulsed low during STREAM -> outputs 0 immediately, no queryDone, next query behaves normally.
